// File: rtl/seq_alu_if.sv
// Handshake and result bundle between the EX-stage issuer and seq_alu.
// The issuer drives operands; the ALU returns result, flags and ready.
interface seq_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             set_flags;
   logic             out_valid;
   logic [WIDTH-1:0] out;
   logic             z;
   logic             n;
   logic             c;
   logic             v;
   logic             busy;

   modport master (
      output in_valid, op, a, b, set_flags,
      input  in_ready, out_valid, out, z, n, c, v, busy
   );

   modport slave (
      input  in_valid, op, a, b, set_flags,
      output in_ready, out_valid, out, z, n, c, v, busy
   );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with NZCV flags: single-cycle ops plus
// iterative shift-add MUL and restoring UDIV.
module seq_alu #(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1,
   parameter int DIV_EN = 1
) (
   input logic      clk,
   input logic      reset,
   seq_alu_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);
   localparam logic [3:0] OP_MUL = 4'b1110;
   localparam logic [3:0] OP_DIV = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_t;

   state_t state, state_nx;

   logic [SW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] acc, acc_nx;
   logic [WIDTH-1:0] opa, opa_nx;
   logic [WIDTH-1:0] opb, opb_nx;
   logic             it_sf, it_sf_nx;

   logic             s1_vld, s1_vld_nx;
   logic [3:0]       s1_op, s1_op_nx;
   logic [WIDTH-1:0] s1_a, s1_a_nx;
   logic [WIDTH-1:0] s1_b, s1_b_nx;
   logic             s1_sf, s1_sf_nx;
   logic             s1_cin, s1_cin_nx;

   logic [WIDTH-1:0] out_q;
   logic             ov_q;
   logic             fn, fz, fc, fv;

   logic             accept;
   logic             is_mul, is_div;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo;

   logic [WIDTH-1:0] res;
   logic             c_nx, v_nx;
   logic             add;
   logic [WIDTH-1:0] x, y;
   logic             ci;
   logic [WIDTH:0]   sum;
   logic [SW-1:0]    amt;
   logic [WIDTH:0]   shl, shr, sar;

   assign accept = bus.in_valid && (state == IDLE);
   assign is_mul = (bus.op == OP_MUL) && (MUL_EN != 0);
   assign is_div = (bus.op == OP_DIV) && (DIV_EN != 0);

   assign mul_acc = acc + (opb[0] ? opa : '0);
   assign rem_sh  = {acc, opa[WIDTH-1]};
   assign rem_ge  = rem_sh >= {1'b0, opb};
   assign rem_nx  = rem_ge ? rem_sh[WIDTH-1:0] - opb
                           : rem_sh[WIDTH-1:0];
   assign quo     = {opa[WIDTH-2:0], rem_ge};

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opa    <= '0;
         opb    <= '0;
         it_sf  <= 1'b0;
         s1_vld <= 1'b0;
         s1_op  <= '0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_sf  <= 1'b0;
         s1_cin <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         acc    <= acc_nx;
         opa    <= opa_nx;
         opb    <= opb_nx;
         it_sf  <= it_sf_nx;
         s1_vld <= s1_vld_nx;
         s1_op  <= s1_op_nx;
         s1_a   <= s1_a_nx;
         s1_b   <= s1_b_nx;
         s1_sf  <= s1_sf_nx;
         s1_cin <= s1_cin_nx;
      end
   end

   // Every result, iterative or not, funnels through the s1 register
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      acc_nx    = acc;
      opa_nx    = opa;
      opb_nx    = opb;
      it_sf_nx  = it_sf;
      s1_vld_nx = 1'b0;
      s1_op_nx  = s1_op;
      s1_a_nx   = s1_a;
      s1_b_nx   = s1_b;
      s1_sf_nx  = s1_sf;
      s1_cin_nx = s1_cin;
      unique case (state)
         IDLE: begin
            if (accept) begin
               it_sf_nx = bus.set_flags;
               cnt_nx   = '0;
               acc_nx   = '0;
               opa_nx   = bus.a;
               opb_nx   = bus.b;
               if (is_mul) begin
                  state_nx = MUL;
               end else if (is_div) begin
                  state_nx = DIV;
               end else begin
                  s1_vld_nx = 1'b1;
                  s1_op_nx  = bus.op;
                  s1_a_nx   = bus.a;
                  s1_b_nx   = bus.b;
                  s1_sf_nx  = bus.set_flags;
                  s1_cin_nx = fc;
               end
            end
         end
         MUL: begin
            acc_nx = mul_acc;
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx  = IDLE;
               s1_vld_nx = 1'b1;
               s1_op_nx  = OP_MUL;
               s1_a_nx   = mul_acc;
               s1_sf_nx  = it_sf;
            end
         end
         DIV: begin
            acc_nx = rem_nx;
            opa_nx = quo;
            cnt_nx = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx  = IDLE;
               s1_vld_nx = 1'b1;
               s1_op_nx  = OP_DIV;
               s1_a_nx   = quo;
               s1_b_nx   = opb;
               s1_sf_nx  = it_sf;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign amt = s1_b[SW-1:0];
   assign shl = {1'b0, s1_a} << amt;
   assign shr = {s1_a, 1'b0} >> amt;
   assign sar = $signed({s1_a, 1'b0}) >>> amt;
   assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

   always_comb begin
      res  = '0;
      c_nx = fc;
      v_nx = fv;
      add  = 1'b0;
      x    = s1_a;
      y    = s1_b;
      ci   = 1'b0;
      unique case (s1_op)
         4'b0000: add = 1'b1;
         4'b0001: begin
            add = 1'b1;
            ci  = s1_cin;
         end
         4'b0010: begin
            add = 1'b1;
            y   = ~s1_b;
            ci  = 1'b1;
         end
         4'b0011: begin
            add = 1'b1;
            y   = ~s1_b;
            ci  = s1_cin;
         end
         4'b0100: begin
            add = 1'b1;
            x   = s1_b;
            y   = ~s1_a;
            ci  = 1'b1;
         end
         4'b0101: res = s1_a & s1_b;
         4'b0110: res = s1_a | s1_b;
         4'b0111: res = s1_a ^ s1_b;
         4'b1000: res = s1_a & ~s1_b;
         4'b1001: res = s1_b;
         4'b1010: res = ~s1_b;
         4'b1011: begin
            res = shl[WIDTH-1:0];
            if (amt != '0) c_nx = shl[WIDTH];
         end
         4'b1100: begin
            res = shr[WIDTH:1];
            if (amt != '0) c_nx = shr[0];
         end
         4'b1101: begin
            res = sar[WIDTH:1];
            if (amt != '0) c_nx = sar[0];
         end
         4'b1110: begin
            if (MUL_EN != 0) res = s1_a;
         end
         4'b1111: begin
            if (DIV_EN != 0) begin
               if (s1_b == '0) begin
                  res  = '1;
                  v_nx = 1'b1;
               end else begin
                  res  = s1_a;
                  v_nx = 1'b0;
               end
            end
         end
         default: res = '0;
      endcase
      // Overflow: like-signed inputs producing an opposite-signed sum
      if (add) begin
         res  = sum[WIDTH-1:0];
         c_nx = sum[WIDTH];
         v_nx = (x[WIDTH-1] == y[WIDTH-1]) &&
                (sum[WIDTH-1] != x[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         ov_q  <= 1'b0;
         fn    <= 1'b0;
         fz    <= 1'b0;
         fc    <= 1'b0;
         fv    <= 1'b0;
      end else begin
         ov_q <= s1_vld;
         if (s1_vld) begin
            out_q <= res;
            if (s1_sf) begin
               fn <= res[WIDTH-1];
               fz <= (res == '0);
               fc <= c_nx;
               fv <= v_nx;
            end
         end
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = ov_q;
   assign bus.out       = out_q;
   assign bus.n         = fn;
   assign bus.z         = fz;
   assign bus.c         = fc;
   assign bus.v         = fv;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed corner cases plus
// random sequential and back-to-back streams against a reference model.
module tb_seq_alu;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(
      .WIDTH (W),
      .MUL_EN(1),
      .DIV_EN(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] out;
      logic [3:0]  nzcv;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_ov = 0;
   int busy_cyc = 0;
   bit m_n, m_z, m_c, m_v;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && !bus.in_ready) busy_cyc++;
      if (!reset && bus.out_valid) begin
         last_ov = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid out=%h", bus.out);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.out !== mon_e.out) begin
               errors++;
               $display("FAIL out_op%0d actual=%h required=%h",
                        mon_e.op, bus.out, mon_e.out);
            end
            checks++;
            if ({bus.n, bus.z, bus.c, bus.v} !== mon_e.nzcv) begin
               errors++;
               $display("FAIL nzcv_op%0d actual=%b required=%b",
                        mon_e.op, {bus.n, bus.z, bus.c, bus.v},
                        mon_e.nzcv);
            end
         end
      end
   end

   function automatic bit ovf(longint x);
      longint t;
      t = longint'($signed(x[31:0]));
      return t != x;
   endfunction

   function automatic void model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic sf,
                                 output logic [31:0] r);
      longint unsigned ua, ub, s;
      longint sa, sb, cl;
      logic [31:0] nb;
      int amt;
      bit mc, mv;
      mc = m_c;
      mv = m_v;
      ua = 64'(a);
      ub = 64'(b);
      nb = ~b;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      cl = m_c ? 64'sd1 : 64'sd0;
      amt = int'(b[4:0]);
      r = 32'h0;
      s = 64'h0;
      case (op)
         4'd0: begin
            s = ua + ub;
            r = s[31:0]; mc = s[32]; mv = ovf(sa + sb);
         end
         4'd1: begin
            s = ua + ub + 64'(cl);
            r = s[31:0]; mc = s[32]; mv = ovf(sa + sb + cl);
         end
         4'd2: begin
            r = a - b; mc = (a >= b); mv = ovf(sa - sb);
         end
         4'd3: begin
            s = ua + 64'(nb) + 64'(cl);
            r = s[31:0]; mc = s[32]; mv = ovf(sa - sb - 1 + cl);
         end
         4'd4: begin
            r = b - a; mc = (b >= a); mv = ovf(sb - sa);
         end
         4'd5: r = a & b;
         4'd6: r = a | b;
         4'd7: r = a ^ b;
         4'd8: r = a & ~b;
         4'd9: r = b;
         4'd10: r = ~b;
         4'd11: begin
            r = a << amt;
            if (amt != 0) mc = a[32-amt];
         end
         4'd12: begin
            r = a >> amt;
            if (amt != 0) mc = a[amt-1];
         end
         4'd13: begin
            r = $signed(a) >>> amt;
            if (amt != 0) mc = a[amt-1];
         end
         4'd14: begin
            s = ua * ub;
            r = s[31:0];
         end
         default: begin
            if (b == 0) begin
               r = 32'hFFFF_FFFF; mv = 1'b1;
            end else begin
               r = a / b; mv = 1'b0;
            end
         end
      endcase
      if (sf) begin
         m_n = r[31];
         m_z = (r == 0);
         m_c = mc;
         m_v = mv;
      end
   endfunction

   function automatic logic [31:0] rv();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic issue(logic [3:0] op, logic [31:0] a,
                        logic [31:0] b, logic sf);
      int k;
      exp_t e;
      logic [31:0] r;
      k = 0;
      while (!bus.in_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout op=%0d", op);
         return;
      end
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.a         = a;
      bus.b         = b;
      bus.set_flags = sf;
      model(op, a, b, sf, r);
      e.op = op;
      e.out = r;
      e.nzcv = {m_n, m_z, m_c, m_v};
      exp_q.push_back(e);
      @(posedge clk); #1;
      acc_cyc = cyc;
      busy_cyc = 0;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL result_timeout pending=%0d", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   initial begin
      int first;
      logic [3:0] op;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.op = 4'h0;
      bus.a = '0;
      bus.b = '0;
      bus.set_flags = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst_out", bus.out, 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_busy", 32'(bus.busy), 0);

      issue(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
      wait_done();
      chk("add_latency", 32'(last_ov - acc_cyc), 1);
      chk("add_ovf_out", bus.out, 32'h8000_0000);
      chk("add_ovf_nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b1001);

      issue(4'd2, 32'd5, 32'd5, 1'b1);
      wait_done();
      chk("sub_eq_nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b0110);
      issue(4'd1, 32'd1, 32'd1, 1'b1);
      wait_done();
      chk("adc_out", bus.out, 32'd3);
      issue(4'd3, 32'd5, 32'd3, 1'b1);
      wait_done();
      chk("sbc_out", bus.out, 32'd1);

      issue(4'd14, 32'h9C00_0038, 32'h7000_0003, 1'b1);
      wait_done();
      chk("mul_out", bus.out, 32'h5400_00A8);
      chk("mul_latency", 32'(last_ov - acc_cyc), 32'd33);
      chk("mul_busy_cycles", 32'(busy_cyc), 32'd32);

      issue(4'd15, 32'd100, 32'd7, 1'b1);
      repeat (10) begin
         bus.in_valid = $urandom_range(0, 1);
         bus.op = 4'($urandom);
         bus.a = $urandom;
         bus.b = $urandom;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_done();
      chk("udiv_out", bus.out, 32'd14);
      chk("udiv_v", 32'(bus.v), 0);
      issue(4'd15, 32'h1234_5678, 32'h0, 1'b1);
      wait_done();
      chk("udiv0_out", bus.out, 32'hFFFF_FFFF);
      chk("udiv0_v", 32'(bus.v), 1);

      issue(4'd11, 32'h8000_0001, 32'd1, 1'b1);
      wait_done();
      chk("lsl_out", bus.out, 32'h2);
      chk("lsl_c", 32'(bus.c), 1);
      issue(4'd11, 32'h1234_5678, 32'h20, 1'b1);
      wait_done();
      chk("lsl0_out", bus.out, 32'h1234_5678);
      chk("lsl0_c", 32'(bus.c), 1);
      issue(4'd0, 32'h0, 32'h0, 1'b0);
      wait_done();
      chk("noflag_out", bus.out, 32'h0);
      chk("noflag_nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'b0011);

      issue(4'd14, $urandom, $urandom, 1'b1);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      m_n = 0; m_z = 0; m_c = 0; m_v = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_in_ready", 32'(bus.in_ready), 1);
      chk("abort_nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 0);
      chk("abort_out_valid", 32'(bus.out_valid), 0);
      repeat (40) @(posedge clk);
      #1;
      issue(4'd0, 32'd2, 32'd3, 1'b1);
      wait_done();
      chk("post_abort_add", bus.out, 32'd5);

      repeat (300) begin
         issue(4'($urandom), rv(), rv(), 1'($urandom));
         wait_done();
      end

      first = -1;
      repeat (20) begin
         do op = 4'($urandom_range(0, 13));
         while (op == 4'd1 || op == 4'd3);
         issue(op, rv(), rv(), 1'($urandom));
         if (first < 0) first = acc_cyc;
      end
      wait_done();
      chk("b2b_span", 32'(last_ov - first), 32'd20);

      repeat (200) begin
         do op = 4'($urandom);
         while (op == 4'd1 || op == 4'd3);
         issue(op, rv(), rv(), 1'($urandom));
      end
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
